// File: rtl/serial_addsub_pkg.sv
// Shared state encoding and full-adder truth tables for the bit-serial add/sub unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Indexed by {a, b, cin}: sum is odd parity, carry is majority.
  localparam logic [7:0] FA_SUM_TT   = 8'h96;
  localparam logic [7:0] FA_CARRY_TT = 8'hE8;

endpackage

// File: rtl/mux_8x1.sv
// 8:1 multiplexer used as a 3-input truth-table lookup.
module mux_8x1 (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/serial_addsub_mux.sv
// Bit-serial (LSB first) adder/subtractor built around one mux-based full-adder cell.
// Define SERIAL_ADDSUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_addsub_mux
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] sh_a, sh_b, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [2:0]       sel;
  logic             s, c;

  assign sel = {sh_a[0], sh_b[0], carry};

  mux_8x1 u_sum   (.d(FA_SUM_TT),   .s(sel), .y(s));
  mux_8x1 u_carry (.d(FA_CARRY_TT), .s(sel), .y(c));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          // Subtract as a + ~b + 1: the +1 enters through the initial carry.
          sh_a  <= a;
          sh_b  <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          acc   <= {s, acc[WIDTH-1:1]};
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            result <= {s, acc[WIDTH-1:1]};
            cout   <= c;
`ifdef SERIAL_ADDSUB_OVF_EN
            // carry still holds the carry into the MSB at this point.
            ovf    <= carry ^ c;
`endif
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_mux.sv
// Directed self-checking bench for serial_addsub_mux (WIDTH=8).
// Define SERIAL_ADDSUB_OVF_EN at compile time to also check ovf.
module tb_serial_addsub_mux;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, sub;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;
  logic             ovf;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

`ifdef SERIAL_ADDSUB_OVF_EN
  serial_addsub_mux #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );
`else
  serial_addsub_mux #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout)
  );
  assign ovf = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation from IDLE (called at posedge+1) and check the full transaction.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic [7:0] er, input logic ec,
                        input logic eo);
    logic [7:0] prev;
    int nb, edges;
    bit stable;
    a = ia; b = ib; sub = isub; start = 1'b1;
    prev = result;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hxx; b = 8'hxx; sub = 1'bx;
    nb = 0; edges = 0; stable = 1;
    while (!done && edges < 20) begin
      if (busy) nb++;
      if (result !== prev) stable = 0;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".edges"}, edges, WIDTH);
    chk({tag, ".busy_cycles"}, nb, WIDTH);
    chk({tag, ".result_held"}, stable, 1);
    chk({tag, ".result"}, result, er);
    chk({tag, ".cout"}, cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({tag, ".ovf"}, ovf, eo);
`else
    if (eo === 1'bz) chk({tag, ".ovf"}, ovf, 0);
`endif
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
  endtask

  function automatic logic [7:0] fa(input int n); return 8'(n * 19 + 7);  endfunction
  function automatic logic [7:0] fb(input int n); return 8'(n * 5 + 33);  endfunction

  initial begin
    logic [8:0] sum9;
    int pulses;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("reset.busy",   busy,   0);
    chk("reset.done",   done,   0);
    chk("reset.result", result, 0);
    chk("reset.cout",   cout,   0);
    chk("reset.ovf",    ovf,    0);

    run_op("add",      8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("wrap",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub_brw",  8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_nobr", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);

    // Abandon an operation in its 4th RUN cycle.
    a = 8'hAB; b = 8'h11; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst.busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.busy",   busy,   0);
    chk("midrst.done",   done,   0);
    chk("midrst.result", result, 0);
    chk("midrst.cout",   cout,   0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    a = 8'h33; b = 8'h44; sub = 1'b0; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start.busy", busy, 0);
    @(posedge clk); #1;
    chk("rst_start.busy2", busy, 0);

    // start held high with operands changing every cycle: captures at n=0,10,20.
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      a = fa(n); b = fb(n); sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      if (done) pulses++;
      if (n % 10 == 8) begin
        sum9 = {1'b0, fa(n - 8)} + {1'b0, fb(n - 8)};
        chk($sformatf("held.done@%0d", n),   done,   1);
        chk($sformatf("held.result@%0d", n), result, sum9[7:0]);
        chk($sformatf("held.cout@%0d", n),   cout,   sum9[8]);
      end
    end
    start = 1'b0;
    chk("held.pulses", pulses, 3);
    @(posedge clk); #1;

    run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("ovf_neg", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("no_ovf",  8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
